// File: rtl/bclksclk_train_sched.sv
// bclksclk_train_sched
// Schedules BCLK/SCLK alignment training for NUM_LANES IOD lanes that share
// one alignment engine. Lane requests are arbitrated round-robin. The granted
// lane index drives the engine-side mux. Each attempt has a timeout, and a
// failed attempt is retried a bounded number of times through the engine
// restart pulse. Per-lane done/error status is sticky.
//
// Ports:
//   sclk_i            system clock, all logic on the rising edge
//   resetn_i          asynchronous active-low reset
//   lane_req_i        level request per lane
//   lane_gnt_o        one-hot grant (registered)
//   lane_sel_o        binary index of the granted lane (engine mux select)
//   lane_done_o       sticky per-lane training success
//   lane_err_o        sticky per-lane training failure
//   train_start_o     engine start, level held through WAIT
//   train_done_i      engine done
//   algn_err_i        engine alignment error
//   algn_rstrt_o      one-cycle engine restart pulse
//   busy_o            high whenever the FSM is not in IDLE
//   all_done_o        registered AND of lane_done_o
//   last_train_cyc_o  START+WAIT cycles of the last completed training,
//                     saturating (only when BCLKSCLK_SCHED_CYCCNT_EN is defined)
//
// Optional build macro: BCLKSCLK_SCHED_CYCCNT_EN
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no lane granted, waiting for any request
// SETTLE   | grant registered, engine mux settling for SETTLE_CYC cycles
// START    | one cycle that arms the attempt timer (TRAIN_START next cycle)
// WAIT     | TRAIN_START high, waiting for done/error/timeout/abort
// RELEASE  | grant dropped, round-robin pointer updated

module bclksclk_train_sched #(
    parameter int NUM_LANES   = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_RETRY   = 2,
    localparam int SEL_W      = $clog2(NUM_LANES)
) (
    input  logic                 sclk_i,
    input  logic                 resetn_i,
    input  logic [NUM_LANES-1:0] lane_req_i,
    output logic [NUM_LANES-1:0] lane_gnt_o,
    output logic [SEL_W-1:0]     lane_sel_o,
    output logic [NUM_LANES-1:0] lane_done_o,
    output logic [NUM_LANES-1:0] lane_err_o,
    output logic                 train_start_o,
    input  logic                 train_done_i,
    input  logic                 algn_err_i,
    output logic                 algn_rstrt_o,
    output logic                 busy_o,
    output logic                 all_done_o
`ifdef BCLKSCLK_SCHED_CYCCNT_EN
    ,
    output logic [15:0]          last_train_cyc_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] SETTLE_LD   = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LD      = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  MAX_RETRY_L = 3'(MAX_RETRY);

    state_t                 state_q;
    logic [NUM_LANES-1:0]   gnt_q;
    logic [SEL_W-1:0]       sel_q;
    logic [NUM_LANES-1:0]   done_q;
    logic [NUM_LANES-1:0]   err_q;
    logic [NUM_LANES-1:0]   req_q;
    logic [SEL_W-1:0]       ptr_q;
    logic [2:0]             retry_q;
    logic [15:0]            tmr_q;
    logic                   start_q;
    logic                   rstrt_q;
    logic                   busy_q;
    logic                   all_done_q;

    logic                   pick_vld;
    logic [SEL_W-1:0]       pick_idx;
    logic [SEL_W-1:0]       cand;
    logic [NUM_LANES-1:0]   pick_oh;
    logic [NUM_LANES-1:0]   req_rise;
    logic                   in_wait;
    logic                   pass_raw;
    logic                   ev_abort;
    logic                   ev_pass;
    logic                   ev_fail;
    logic                   retry_ok;

    // Round-robin: first requester strictly after the last lane served.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        pick_oh  = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = SEL_W'((int'(ptr_q) + k) % NUM_LANES);
            if (!pick_vld && lane_req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        pick_oh[pick_idx] = 1'b1;
    end

    // WAIT resolution: abort beats done, done beats error/timeout.
    always_comb begin
        req_rise = lane_req_i & ~req_q;
        in_wait  = (state_q == ST_WAIT);
        pass_raw = train_done_i && !algn_err_i;
        ev_abort = in_wait && !lane_req_i[sel_q];
        ev_pass  = in_wait && lane_req_i[sel_q] && pass_raw;
        ev_fail  = in_wait && lane_req_i[sel_q] && !pass_raw &&
                   (algn_err_i || (tmr_q == 16'd0));
        retry_ok = (retry_q < MAX_RETRY_L);
    end

    always_ff @(posedge sclk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            req_q      <= '0;
            ptr_q      <= '0;
            retry_q    <= '0;
            tmr_q      <= '0;
            start_q    <= 1'b0;
            rstrt_q    <= 1'b0;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            req_q      <= lane_req_i;
            rstrt_q    <= 1'b0;
            all_done_q <= &done_q;
            // A fresh request wipes old status so re-training starts clean.
            done_q     <= done_q & ~req_rise;
            err_q      <= err_q & ~req_rise;

            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_oh;
                        sel_q   <= pick_idx;
                        retry_q <= '0;
                        tmr_q   <= SETTLE_LD;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == 16'd0) begin
                        state_q <= ST_START;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                ST_START: begin
                    start_q <= 1'b1;
                    tmr_q   <= TMO_LD;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ev_abort || ev_pass || (ev_fail && !retry_ok)) begin
                        start_q <= 1'b0;
                        gnt_q   <= '0;
                        state_q <= ST_RELEASE;
                        if (ev_pass) begin
                            done_q[sel_q] <= 1'b1;
                            err_q[sel_q]  <= 1'b0;
                        end else if (ev_fail) begin
                            err_q[sel_q]  <= 1'b1;
                            done_q[sel_q] <= 1'b0;
                        end
                    end else if (ev_fail) begin
                        start_q <= 1'b0;
                        rstrt_q <= 1'b1;
                        retry_q <= retry_q + 3'd1;
                        tmr_q   <= SETTLE_LD;
                        state_q <= ST_SETTLE;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                ST_RELEASE: begin
                    ptr_q   <= sel_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lane_gnt_o    = gnt_q;
    assign lane_sel_o    = sel_q;
    assign lane_done_o   = done_q;
    assign lane_err_o    = err_q;
    assign train_start_o = start_q;
    assign algn_rstrt_o  = rstrt_q;
    assign busy_o        = busy_q;
    assign all_done_o    = all_done_q;

`ifdef BCLKSCLK_SCHED_CYCCNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cyc_inc;
    logic [15:0] last_cyc_q;

    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 16'd1;

    // Accumulates START and WAIT cycles across retries of one grant; the
    // cycle that resolves WAIT is included via cyc_inc when loading.
    always_ff @(posedge sclk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cyc_q      <= '0;
            last_cyc_q <= '0;
        end else begin
            if (state_q == ST_IDLE && pick_vld) begin
                cyc_q <= '0;
            end else if (state_q == ST_START || (in_wait && !ev_abort)) begin
                cyc_q <= cyc_inc;
            end
            if (ev_pass || (ev_fail && !retry_ok)) begin
                last_cyc_q <= cyc_inc;
            end
        end
    end

    assign last_train_cyc_o = last_cyc_q;
`endif

endmodule

// File: tb/tb_bclksclk_train_sched.sv
module tb_bclksclk_train_sched;

    logic       sclk = 1'b0;
    logic       resetn_i = 1'b0;
    logic [3:0] lane_req_i = 4'b0000;
    logic       train_done_i = 1'b0;
    logic       algn_err_i = 1'b0;
    logic [3:0] lane_gnt_o;
    logic [1:0] lane_sel_o;
    logic [3:0] lane_done_o;
    logic [3:0] lane_err_o;
    logic       train_start_o;
    logic       algn_rstrt_o;
    logic       busy_o;
    logic       all_done_o;
`ifdef BCLKSCLK_SCHED_CYCCNT_EN
    logic [15:0] last_train_cyc_o;
`endif

    bclksclk_train_sched #(
        .NUM_LANES  (4),
        .SETTLE_CYC (8),
        .TIMEOUT_CYC(64),
        .MAX_RETRY  (2)
    ) dut (
        .sclk_i       (sclk),
        .resetn_i     (resetn_i),
        .lane_req_i   (lane_req_i),
        .lane_gnt_o   (lane_gnt_o),
        .lane_sel_o   (lane_sel_o),
        .lane_done_o  (lane_done_o),
        .lane_err_o   (lane_err_o),
        .train_start_o(train_start_o),
        .train_done_i (train_done_i),
        .algn_err_i   (algn_err_i),
        .algn_rstrt_o (algn_rstrt_o),
        .busy_o       (busy_o),
        .all_done_o   (all_done_o)
`ifdef BCLKSCLK_SCHED_CYCCNT_EN
        ,
        .last_train_cyc_o(last_train_cyc_o)
`endif
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int lane;
        bit done;
        bit err;
    } res_t;

    int   exp_gnt_q[$];
    res_t exp_res_q[$];

    int errors = 0;
    int checks = 0;

    // Edge/pulse counters for TRAIN_START and ALGN_RSTRT, sampled mid-cycle.
    logic start_prev = 1'b0;
    logic rstrt_prev = 1'b0;
    int   start_rise = 0;
    int   rstrt_rise = 0;
    int   rstrt_hi   = 0;

    always @(negedge sclk) begin
        if (train_start_o && !start_prev) start_rise++;
        if (algn_rstrt_o && !rstrt_prev) rstrt_rise++;
        if (algn_rstrt_o) rstrt_hi++;
        start_prev = train_start_o;
        rstrt_prev = algn_rstrt_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic wait_grant(output int lane);
        int n = 0;
        int exp;
        while (lane_gnt_o == 4'b0000 && n < 300) begin
            tick(1);
            n++;
        end
        exp  = (exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : -1;
        lane = int'(lane_sel_o);
        chk("grant_lane", 32'(lane), 32'(exp));
        chk("grant_onehot", 32'(lane_gnt_o), 32'(1) << exp);
    endtask

    task automatic wait_start();
        int n = 0;
        while (train_start_o !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("start_seen", 32'(train_start_o), 32'(1));
    endtask

    // Engine model: respond dly cycles after TRAIN_START is first seen.
    task automatic engine(input int dly, input bit d, input bit e);
        wait_start();
        tick(dly);
        train_done_i = d;
        algn_err_i   = e;
        tick(1);
        train_done_i = 1'b0;
        algn_err_i   = 1'b0;
    endtask

    task automatic check_result();
        res_t r;
        checks++;
        if (exp_res_q.size() == 0) begin
            errors++;
            $error("FAIL result_queue: observed=empty expected=entry");
        end else begin
            r = exp_res_q.pop_front();
            chk("lane_done_bit", 32'(lane_done_o[r.lane]), 32'(r.done));
            chk("lane_err_bit", 32'(lane_err_o[r.lane]), 32'(r.err));
        end
    endtask

    int lane;
    int n;
    int base_start;
    int base_rise;
    int base_hi;

    initial begin
        // Reset state
        tick(2);
        chk("rst_gnt", 32'(lane_gnt_o), 32'(0));
        chk("rst_sel", 32'(lane_sel_o), 32'(0));
        chk("rst_done", 32'(lane_done_o), 32'(0));
        chk("rst_err", 32'(lane_err_o), 32'(0));
        chk("rst_start", 32'(train_start_o), 32'(0));
        chk("rst_rstrt", 32'(algn_rstrt_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_alldone", 32'(all_done_o), 32'(0));
        resetn_i = 1'b1;
        tick(2);

        // Single lane: grant after 1 cycle, TRAIN_START after 10, DONE 20 later
        exp_gnt_q.push_back(2);
        exp_res_q.push_back('{lane: 2, done: 1'b1, err: 1'b0});
        lane_req_i = 4'b0100;
        tick(1);
        chk("single_gnt_latency", 32'(lane_gnt_o), 32'(4'b0100));
        wait_grant(lane);
        tick(8);
        chk("single_start_early", 32'(train_start_o), 32'(0));
        tick(1);
        chk("single_start_latency", 32'(train_start_o), 32'(1));
        tick(20);
        train_done_i = 1'b1;
        tick(1);
        train_done_i = 1'b0;
        check_result();
        chk("single_done_vec", 32'(lane_done_o), 32'(4'b0100));
        chk("single_busy_release", 32'(busy_o), 32'(1));
        lane_req_i = 4'b0000;
        tick(1);
        chk("single_busy_idle", 32'(busy_o), 32'(0));

        // Round-robin from a fresh reset: 1,2,3,0
        resetn_i = 1'b0;
        tick(2);
        resetn_i = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back((i + 1) % 4);
            exp_res_q.push_back('{lane: (i + 1) % 4, done: 1'b1, err: 1'b0});
        end
        lane_req_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(lane);
            engine(5, 1'b1, 1'b0);
            check_result();
            lane_req_i[lane] = 1'b0;
        end
        chk("rr_alldone_lag", 32'(all_done_o), 32'(0));
        tick(1);
        chk("rr_alldone", 32'(all_done_o), 32'(1));

        // Retry success on lane 1 (re-raised request clears its old status)
        base_rise = rstrt_rise;
        base_hi   = rstrt_hi;
        exp_gnt_q.push_back(1);
        exp_res_q.push_back('{lane: 1, done: 1'b1, err: 1'b0});
        lane_req_i = 4'b0010;
        wait_grant(lane);
        chk("rereq_cleared", 32'(lane_done_o), 32'(4'b1101));
        tick(1);
        chk("rereq_alldone_drop", 32'(all_done_o), 32'(0));
        engine(3, 1'b0, 1'b1);
        chk("retry_rstrt_now", 32'(algn_rstrt_o), 32'(1));
        engine(4, 1'b1, 1'b0);
        check_result();
        lane_req_i = 4'b0000;
        chk("retry_rstrt_pulses", 32'(rstrt_rise - base_rise), 32'(1));
        chk("retry_rstrt_width", 32'(rstrt_hi - base_hi), 32'(1));

        // Timeout exhaustion on lane 3, then lane 0 gets the grant
        base_start = start_rise;
        base_rise  = rstrt_rise;
        base_hi    = rstrt_hi;
        exp_gnt_q.push_back(3);
        exp_gnt_q.push_back(0);
        exp_res_q.push_back('{lane: 3, done: 1'b0, err: 1'b1});
        exp_res_q.push_back('{lane: 0, done: 1'b1, err: 1'b0});
        lane_req_i = 4'b1001;
        wait_grant(lane);
        wait_start();
        n = 0;
        while (train_start_o && n < 200) begin
            tick(1);
            n++;
        end
        chk("tmo_attempt_len", 32'(n), 32'(64));
        n = 0;
        while (!lane_err_o[3] && n < 400) begin
            tick(1);
            n++;
        end
        check_result();
        chk("tmo_attempts", 32'(start_rise - base_start), 32'(3));
        chk("tmo_rstrt_pulses", 32'(rstrt_rise - base_rise), 32'(2));
        chk("tmo_rstrt_width", 32'(rstrt_hi - base_hi), 32'(2));
        lane_req_i[3] = 1'b0;
        wait_grant(lane);
        engine(2, 1'b1, 1'b0);
        check_result();
        lane_req_i[0] = 1'b0;

        // DONE on the very cycle the timeout expires: success wins
        base_rise = rstrt_rise;
        exp_gnt_q.push_back(2);
        exp_res_q.push_back('{lane: 2, done: 1'b1, err: 1'b0});
        lane_req_i = 4'b0100;
        wait_grant(lane);
        engine(63, 1'b1, 1'b0);
        check_result();
        chk("tie_no_rstrt", 32'(rstrt_rise - base_rise), 32'(0));
        lane_req_i = 4'b0000;

        // REQ dropped mid-WAIT together with DONE: abort, no status change
        base_rise = rstrt_rise;
        exp_gnt_q.push_back(1);
        exp_res_q.push_back('{lane: 1, done: 1'b0, err: 1'b0});
        lane_req_i = 4'b0010;
        wait_grant(lane);
        wait_start();
        tick(10);
        lane_req_i   = 4'b0000;
        train_done_i = 1'b1;
        tick(1);
        train_done_i = 1'b0;
        check_result();
        chk("abort_done_vec", 32'(lane_done_o), 32'(4'b0101));
        chk("abort_err_vec", 32'(lane_err_o), 32'(4'b1000));
        chk("abort_start_drop", 32'(train_start_o), 32'(0));
        chk("abort_gnt_drop", 32'(lane_gnt_o), 32'(0));
        tick(1);
        chk("abort_busy_idle", 32'(busy_o), 32'(0));
        chk("abort_no_rstrt", 32'(rstrt_rise - base_rise), 32'(0));

        // Reset pulsed mid-WAIT: outputs clear without waiting for a clock
        base_rise = rstrt_rise;
        exp_gnt_q.push_back(3);
        lane_req_i = 4'b1000;
        wait_grant(lane);
        wait_start();
        tick(5);
        resetn_i = 1'b0;
        #1;
        chk("arst_start", 32'(train_start_o), 32'(0));
        chk("arst_gnt", 32'(lane_gnt_o), 32'(0));
        chk("arst_sel", 32'(lane_sel_o), 32'(0));
        chk("arst_busy", 32'(busy_o), 32'(0));
        chk("arst_done", 32'(lane_done_o), 32'(0));
        chk("arst_err", 32'(lane_err_o), 32'(0));
        chk("arst_rstrt", 32'(algn_rstrt_o), 32'(0));
        lane_req_i = 4'b0000;
        tick(2);
        chk("arst_no_rstrt", 32'(rstrt_rise - base_rise), 32'(0));
        resetn_i = 1'b1;
        tick(2);

`ifdef BCLKSCLK_SCHED_CYCCNT_EN
        // START state is the cycle before TRAIN_START is seen; DONE 30
        // cycles after START gives 1 START + 30 WAIT cycles.
        chk("cyc_reset", 32'(last_train_cyc_o), 32'(0));
        exp_gnt_q.push_back(0);
        exp_res_q.push_back('{lane: 0, done: 1'b1, err: 1'b0});
        lane_req_i = 4'b0001;
        wait_grant(lane);
        engine(29, 1'b1, 1'b0);
        check_result();
        chk("cyc_single", 32'(last_train_cyc_o), 32'(31));
        lane_req_i = 4'b0000;
        tick(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
